load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; XLEN, LS_SEL_WIDTH and the LS_TYPE_* codes SHALL come from the shared memory header.
REQ-002 i_Clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 i_Reset  in  1  synchronous, active-high reset.
REQ-004 i_Req_Valid  in  1  execute stage presents a load/store request.
REQ-005 o_Req_Ready  out  1  LSU can accept; a request is taken on a rising edge where valid and ready are both high.
REQ-006 i_Load_Store_Type  in  LS_SEL_WIDTH+1  LS_TYPE_* code of the request.
REQ-007 i_Addr  in  XLEN  byte address.
REQ-008 i_Store_Data  in  XLEN  store operand, right-justified.
REQ-009 o_Done  out  1  one-cycle completion pulse.
REQ-010 o_Load_Data  out  XLEN  extended load result, valid while o_Done is high.
REQ-011 o_Misaligned  out  1  valid with o_Done: the request was misaligned and aborted.
REQ-012 o_Mem_Addr  out  XLEN  word index to memory, equal to the latched byte address >> 2.
REQ-013 o_Mem_Write_Enable  out  1  memory write strobe.
REQ-014 o_Mem_Load_Store_Type  out  LS_SEL_WIDTH+1  always LS_TYPE_LOAD_WORD, or LS_TYPE_STORE_WORD during a write.
REQ-015 o_Mem_Write_Data  out  XLEN  full merged word to memory.
REQ-016 i_Mem_Read_Data  in  XLEN  memory read word, valid one cycle after o_Mem_Addr is presented.

Function
REQ-017 The FSM SHALL have states IDLE, MEM_READ, CAPTURE, MEM_WRITE and RESP.
REQ-018 o_Req_Ready SHALL be 1 only in IDLE; i_Req_Valid outside IDLE SHALL be ignored.
REQ-019 On accept, the address, type and store data SHALL be latched; later changes on the inputs SHALL have no effect.
REQ-020 Misalignment rules: a word access with addr[1:0]!=0 is misaligned; a half access with addr[0]=1 is misaligned.
REQ-021 A misaligned access SHALL go from IDLE to RESP, with o_Done=1, o_Misaligned=1 and o_Load_Data=0 at cycle A+1 (A = accept edge); no write SHALL occur.
REQ-022 Load path: IDLE -> MEM_READ (A+1) -> CAPTURE (A+2) -> RESP (A+3), with o_Done at A+3.
REQ-023 Load extraction SHALL select the lane at addr[1:0] (little-endian): LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-024 The load result SHALL be registered at the end of CAPTURE.
REQ-025 Store-word path: IDLE -> MEM_WRITE (A+1) -> RESP (A+2).
REQ-026 Sub-word store path (SB/SH): IDLE -> MEM_READ -> CAPTURE, merging the store lane into the read word at addr[1:0] -> MEM_WRITE (A+3) -> RESP (A+4).
REQ-027 o_Mem_Write_Enable SHALL be 1 only in MEM_WRITE, exactly one cycle per store.
REQ-028 Unmerged bytes SHALL equal the word read in CAPTURE.
REQ-029 RESP SHALL always return to IDLE the next cycle.
REQ-030 o_Done, o_Misaligned and o_Load_Data SHALL be 0 outside RESP.
REQ-031 An unknown type code SHALL be treated as misaligned (trapped).

Reset
REQ-032 Reset SHALL force state IDLE and set o_Req_Ready=1.
REQ-033 Reset SHALL force o_Done, o_Misaligned, o_Mem_Write_Enable, o_Load_Data, o_Mem_Addr and o_Mem_Write_Data to 0, and o_Mem_Load_Store_Type to LS_TYPE_LOAD_WORD.
REQ-034 Reset in any state, including MEM_WRITE, SHALL take effect at that edge; an interrupted store SHALL NOT write later.

Structure
REQ-035 LS_TYPE_STORE_BYTE and the state encoding SHALL live in the shared memory header alongside the existing LS_TYPE_* codes.
REQ-036 Lane extraction and merge SHALL be one combinational sub-module, lsu_lane_align.
REQ-037 The RTL SHALL connect to the existing memory's data port with no change to that memory.

Verification (word index 4 preloaded with 0x8899AABB)
REQ-038 LB at 0x13 -> o_Load_Data=0xFFFFFF88, o_Done at A+3, no write.
REQ-039 LHU at 0x12 -> 0x00008899; LH at 0x12 -> 0xFFFF8899.
REQ-040 SB 0x1234565A at 0x11 -> one write of 0x88995ABB to index 4 at A+3, o_Done at A+4.
REQ-041 SH at 0x11 -> o_Misaligned=1 and o_Done at A+1, write enable never high.
REQ-042 SW 0xDEADBEEF at 0x10, then LW at 0x10 -> 0xDEADBEEF.
REQ-043 Reset asserted at A+2 of an SB -> no write, o_Req_Ready=1 after the reset edge, memory still 0x8899AABB.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared memory header: widths, LS_TYPE_* codes, LSU state encoding
package load_store_unit_pkg;

  localparam int XLEN         = 32;
  localparam int LS_SEL_WIDTH = 3;

  typedef logic [LS_SEL_WIDTH:0] ls_type_t;

  // Top bit set marks a store; the low bits follow the RISC-V funct3 layout
  localparam ls_type_t LS_TYPE_LOAD_BYTE          = 4'b0000;
  localparam ls_type_t LS_TYPE_LOAD_HALF          = 4'b0001;
  localparam ls_type_t LS_TYPE_LOAD_WORD          = 4'b0010;
  localparam ls_type_t LS_TYPE_LOAD_BYTE_UNSIGNED = 4'b0100;
  localparam ls_type_t LS_TYPE_LOAD_HALF_UNSIGNED = 4'b0101;
  localparam ls_type_t LS_TYPE_STORE_BYTE         = 4'b1000;
  localparam ls_type_t LS_TYPE_STORE_HALF         = 4'b1001;
  localparam ls_type_t LS_TYPE_STORE_WORD         = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MEM_READ  = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_RESP      = 3'd4
  } lsu_state_e;

  // Unknown codes report as misaligned so they trap instead of touching memory
  function automatic logic ls_misaligned(input ls_type_t t, input logic [1:0] off);
    case (t)
      LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_BYTE_UNSIGNED, LS_TYPE_STORE_BYTE: return 1'b0;
      LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_HALF_UNSIGNED, LS_TYPE_STORE_HALF: return off[0];
      LS_TYPE_LOAD_WORD, LS_TYPE_STORE_WORD:                             return off != 2'b00;
      default:                                                           return 1'b1;
    endcase
  endfunction

  function automatic logic ls_is_store(input ls_type_t t);
    return t[LS_SEL_WIDTH];
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian lane extraction for loads and lane merge for stores
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  ls_type_t          i_load_store_type,
  input  logic [1:0]        i_byte_off,
  input  logic [XLEN-1:0]   i_read_word,
  input  logic [XLEN-1:0]   i_store_data,
  output logic [XLEN-1:0]   o_load_data,
  output logic [XLEN-1:0]   o_merged_word
);

  logic [4:0]      shamt;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] placed;
  logic [XLEN-1:0] mask;

  assign shamt  = {i_byte_off, 3'b000};
  assign lane   = i_read_word >> shamt;
  assign placed = i_store_data << shamt;

  always_comb begin
    o_load_data = '0;
    case (i_load_store_type)
      LS_TYPE_LOAD_BYTE:          o_load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      LS_TYPE_LOAD_BYTE_UNSIGNED: o_load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      LS_TYPE_LOAD_HALF:          o_load_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      LS_TYPE_LOAD_HALF_UNSIGNED: o_load_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      LS_TYPE_LOAD_WORD:          o_load_data = lane;
      default:                    o_load_data = '0;
    endcase
  end

  always_comb begin
    mask = '0;
    case (i_load_store_type)
      LS_TYPE_STORE_BYTE: mask = {{(XLEN-8){1'b0}}, 8'hFF} << shamt;
      LS_TYPE_STORE_HALF: mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << shamt;
      LS_TYPE_STORE_WORD: mask = '1;
      default:            mask = '0;
    endcase
    o_merged_word = (i_read_word & ~mask) | (placed & mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit over a word-wide synchronous-read memory port
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Req_Valid,
  output logic              o_Req_Ready,
  input  ls_type_t          i_Load_Store_Type,
  input  logic [XLEN-1:0]   i_Addr,
  input  logic [XLEN-1:0]   i_Store_Data,
  output logic              o_Done,
  output logic [XLEN-1:0]   o_Load_Data,
  output logic              o_Misaligned,
  output logic [XLEN-1:0]   o_Mem_Addr,
  output logic              o_Mem_Write_Enable,
  output ls_type_t          o_Mem_Load_Store_Type,
  output logic [XLEN-1:0]   o_Mem_Write_Data,
  input  logic [XLEN-1:0]   i_Mem_Read_Data
);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  ls_type_t        type_q, type_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] load_q, load_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            mis_q, mis_d;
  logic [XLEN-1:0] lane_load;
  logic [XLEN-1:0] lane_merge;

  lsu_lane_align u_lane_align (
    .i_load_store_type (type_q),
    .i_byte_off        (addr_q[1:0]),
    .i_read_word       (i_Mem_Read_Data),
    .i_store_data      (sdata_q),
    .o_load_data       (lane_load),
    .o_merged_word     (lane_merge)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    type_d  = type_q;
    sdata_d = sdata_q;
    load_d  = load_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Req_Valid) begin
          addr_d  = i_Addr;
          type_d  = i_Load_Store_Type;
          sdata_d = i_Store_Data;
          load_d  = '0;
          mis_d   = 1'b0;
          if (ls_misaligned(i_Load_Store_Type, i_Addr[1:0])) begin
            mis_d   = 1'b1;
            state_d = ST_RESP;
          end else if (i_Load_Store_Type == LS_TYPE_STORE_WORD) begin
            wdata_d = i_Store_Data;
            state_d = ST_MEM_WRITE;
          end else begin
            state_d = ST_MEM_READ;
          end
        end
      end
      ST_MEM_READ: state_d = ST_CAPTURE;
      // Read word is valid here; loads finish, sub-word stores merge into it
      ST_CAPTURE: begin
        if (ls_is_store(type_q)) begin
          wdata_d = lane_merge;
          state_d = ST_MEM_WRITE;
        end else begin
          load_d  = lane_load;
          state_d = ST_RESP;
        end
      end
      ST_MEM_WRITE: state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      type_q  <= LS_TYPE_LOAD_WORD;
      sdata_q <= '0;
      load_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      sdata_q <= sdata_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  assign o_Req_Ready           = (state_q == ST_IDLE);
  assign o_Done                = (state_q == ST_RESP);
  assign o_Misaligned          = o_Done & mis_q;
  assign o_Load_Data           = o_Done ? load_q : '0;
  assign o_Mem_Addr            = {2'b00, addr_q[XLEN-1:2]};
  assign o_Mem_Write_Enable    = (state_q == ST_MEM_WRITE);
  assign o_Mem_Load_Store_Type = o_Mem_Write_Enable ? LS_TYPE_STORE_WORD : LS_TYPE_LOAD_WORD;
  assign o_Mem_Write_Data      = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        valid;
  logic        ready;
  ls_type_t    ltype;
  logic [31:0] addr;
  logic [31:0] sdata;
  logic        done;
  logic [31:0] load_data;
  logic        mis;
  logic [31:0] m_addr;
  logic        m_we;
  ls_type_t    m_type;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  load_store_unit dut (
    .i_Clock               (clk),
    .i_Reset               (rst),
    .i_Req_Valid           (valid),
    .o_Req_Ready           (ready),
    .i_Load_Store_Type     (ltype),
    .i_Addr                (addr),
    .i_Store_Data          (sdata),
    .o_Done                (done),
    .o_Load_Data           (load_data),
    .o_Misaligned          (mis),
    .o_Mem_Addr            (m_addr),
    .o_Mem_Write_Enable    (m_we),
    .o_Mem_Load_Store_Type (m_type),
    .o_Mem_Write_Data      (m_wdata),
    .i_Mem_Read_Data       (m_rdata)
  );

  logic [31:0] mem [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (m_we) mem[m_addr[3:0]] <= m_wdata;
    m_rdata <= mem[m_addr[3:0]];
  end

  logic [7:0] ref_bytes [64];
  int tests = 0;
  int fails = 0;
  ls_type_t codes [8];

  function automatic int ls_size(input ls_type_t t);
    case (t)
      LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_BYTE_UNSIGNED, LS_TYPE_STORE_BYTE: return 1;
      LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_HALF_UNSIGNED, LS_TYPE_STORE_HALF: return 2;
      LS_TYPE_LOAD_WORD, LS_TYPE_STORE_WORD:                             return 4;
      default:                                                           return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_bytes[idx*4 + i];
    return w;
  endfunction

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx[3:0]; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[idx*4 + i] = d[8*i +: 8];
  endtask

  task automatic run_req(input string name, input ls_type_t t, input logic [31:0] a, input logic [31:0] sd);
    int size, exp_done, exp_writes, exp_wcyc, done_cyc, nwrites, wcyc, quiet_err;
    logic exp_mis, is_store, got_mis;
    logic [31:0] exp_load, exp_wdata, got_load, wdata, widx;
    ls_type_t wtype;
    size     = ls_size(t);
    is_store = t[3];
    exp_mis  = (size == 0) || ((a % size) != 0);
    exp_load = 32'h0;
    exp_wdata = 32'h0;
    exp_writes = 0;
    exp_wcyc = (size == 4) ? 1 : 3;
    if (exp_mis) exp_done = 1;
    else if (!is_store) exp_done = 3;
    else exp_done = (size == 4) ? 2 : 4;
    if (!exp_mis && !is_store) begin
      for (int i = 0; i < size; i++) exp_load = exp_load | (32'(ref_bytes[a + i]) << (8*i));
      if ((t == LS_TYPE_LOAD_BYTE || t == LS_TYPE_LOAD_HALF) && exp_load[8*size-1])
        exp_load = exp_load | (32'hFFFF_FFFF << (8*size));
    end
    if (!exp_mis && is_store) begin
      exp_writes = 1;
      for (int i = 0; i < size; i++) ref_bytes[a + i] = sd[8*i +: 8];
      exp_wdata = ref_word(int'(a >> 2));
    end

    @(negedge clk);
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL %s ready_idle got=%b exp=1", name, ready); end
    valid = 1'b1; ltype = t; addr = a; sdata = sd;
    @(posedge clk); #1;
    done_cyc = 0; nwrites = 0; wcyc = 0; quiet_err = 0;
    got_load = 0; got_mis = 0; wdata = 0; widx = 0; wtype = LS_TYPE_LOAD_WORD;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (m_we) begin nwrites++; wcyc = cyc; wdata = m_wdata; widx = m_addr; wtype = m_type; end
      if (done) begin
        done_cyc = cyc; got_load = load_data; got_mis = mis;
        valid = 1'b0;
        break;
      end
      if (mis || load_data != 0 || ready) quiet_err++;
      ltype = ls_type_t'($urandom); addr = $urandom; sdata = $urandom;
    end
    valid = 1'b0;
    @(posedge clk); #1;

    tests++;
    if (done_cyc != exp_done) begin fails++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc, exp_done); end
    tests++;
    if (got_mis !== exp_mis) begin fails++; $display("FAIL %s misaligned got=%b exp=%b", name, got_mis, exp_mis); end
    if (!is_store || exp_mis) begin
      tests++;
      if (got_load !== exp_load) begin fails++; $display("FAIL %s load_data got=%h exp=%h", name, got_load, exp_load); end
    end
    tests++;
    if (nwrites != exp_writes) begin fails++; $display("FAIL %s write_count got=%0d exp=%0d", name, nwrites, exp_writes); end
    if (exp_writes == 1) begin
      tests++;
      if (wcyc != exp_wcyc || wdata !== exp_wdata || widx !== (a >> 2) || wtype !== LS_TYPE_STORE_WORD) begin
        fails++;
        $display("FAIL %s write got cyc=%0d data=%h idx=%h type=%h exp cyc=%0d data=%h idx=%h", name, wcyc, wdata, widx, wtype, exp_wcyc, exp_wdata, a >> 2);
      end
    end
    tests++;
    if (quiet_err != 0) begin fails++; $display("FAIL %s outputs_outside_resp got=%0d exp=0", name, quiet_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; ltype = LS_TYPE_LOAD_WORD; addr = 0; sdata = 0; pre_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ready !== 1'b1 || done !== 1'b0 || mis !== 1'b0 || m_we !== 1'b0) begin
      fails++; $display("FAIL reset_ctrl got ready=%b done=%b mis=%b we=%b exp 1 0 0 0", ready, done, mis, m_we);
    end
    tests++;
    if (load_data !== 32'h0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_data got ld=%h addr=%h wd=%h exp 0", load_data, m_addr, m_wdata);
    end
    tests++;
    if (m_type !== LS_TYPE_LOAD_WORD) begin fails++; $display("FAIL reset_type got=%h exp=%h", m_type, LS_TYPE_LOAD_WORD); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    preload(4, 32'h8899AABB);
    run_req("lb_0x13",  LS_TYPE_LOAD_BYTE,          32'h13, 32'h0);
    run_req("lhu_0x12", LS_TYPE_LOAD_HALF_UNSIGNED, 32'h12, 32'h0);
    run_req("lh_0x12",  LS_TYPE_LOAD_HALF,          32'h12, 32'h0);
    run_req("lbu_0x11", LS_TYPE_LOAD_BYTE_UNSIGNED, 32'h11, 32'h0);
    run_req("sb_0x11",  LS_TYPE_STORE_BYTE,         32'h11, 32'h1234565A);
    run_req("sh_0x11",  LS_TYPE_STORE_HALF,         32'h11, 32'hCAFEF00D);
    run_req("lw_0x12",  LS_TYPE_LOAD_WORD,          32'h12, 32'h0);
    run_req("sw_0x10",  LS_TYPE_STORE_WORD,         32'h10, 32'hDEADBEEF);
    run_req("lw_0x10",  LS_TYPE_LOAD_WORD,          32'h10, 32'h0);
    run_req("bad_code", 4'b1111,                    32'h10, 32'h0);
  endtask

  task automatic test_reset_abort();
    int late_writes;
    preload(4, 32'h8899AABB);
    @(negedge clk);
    valid = 1'b1; ltype = LS_TYPE_STORE_BYTE; addr = 32'h11; sdata = 32'h1234565A;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (ready !== 1'b1 || m_we !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL abort_state got ready=%b we=%b done=%b exp 1 0 0", ready, m_we, done);
    end
    late_writes = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_we) late_writes++;
    end
    tests++;
    if (late_writes != 0) begin fails++; $display("FAIL abort_late_write got=%0d exp=0", late_writes); end
    tests++;
    if (mem[4] !== 32'h8899AABB) begin fails++; $display("FAIL abort_mem got=%h exp=8899aabb", mem[4]); end
    run_req("lw_after_abort", LS_TYPE_LOAD_WORD, 32'h10, 32'h0);
  endtask

  task automatic test_random();
    ls_type_t unknown [8];
    ls_type_t t;
    unknown = '{4'b0011, 4'b0110, 4'b0111, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 9) t = codes[$urandom_range(0, 7)];
      else t = unknown[$urandom_range(0, 7)];
      run_req("random", t, 32'($urandom_range(0, 63)), $urandom);
    end
  endtask

  initial begin
    codes = '{LS_TYPE_LOAD_BYTE, LS_TYPE_LOAD_HALF, LS_TYPE_LOAD_WORD, LS_TYPE_LOAD_BYTE_UNSIGNED,
              LS_TYPE_LOAD_HALF_UNSIGNED, LS_TYPE_STORE_BYTE, LS_TYPE_STORE_HALF, LS_TYPE_STORE_WORD};
    test_reset();
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    test_directed();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
